// File: rtl/program_loader_pkg.sv
// Shared types for the program loader: FSM state encoding, frame geometry and state decode helpers.
// The CHECK state only exists when PROGRAM_LOADER_CHECKSUM_EN is defined.
package loader_pkg;

    localparam int LOADER_LEN_BYTES  = 2;
    localparam int LOADER_WORD_BYTES = 4;
    localparam int LOADER_COUNT_W    = 8 * LOADER_LEN_BYTES;
    localparam int LOADER_WORD_W     = 8 * LOADER_WORD_BYTES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE,
        S_ERROR
    } loader_state_t;

    // States in which the loader is willing to take a stream byte.
    function automatic logic takes_bytes(input loader_state_t s);
        case (s)
            S_LEN_HI, S_LEN_LO, S_DATA: return 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHECK:                    return 1'b1;
`endif
            default:                    return 1'b0;
        endcase
    endfunction

    function automatic logic is_busy(input loader_state_t s);
        return !(s == S_IDLE || s == S_DONE || s == S_ERROR);
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Bundle between host byte link, program memory write port and CPU status for the program loader.
// master = loader side, slave = host/memory/CPU side.
interface program_loader_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [31:0]       dado;
    logic [ADDR_W-1:0] endereco;
    logic              write;
    logic              busy;
    logic              done;
    logic              error;
    logic [15:0]       words_loaded;

    modport master (
        input  start, byte_in, byte_valid,
        output byte_ready, dado, endereco, write, busy, done, error, words_loaded
    );

    modport slave (
        output start, byte_in, byte_valid,
        input  byte_ready, dado, endereco, write, busy, done, error, words_loaded
    );
endinterface

// File: rtl/program_loader_byte_word_packer.sv
// Packs MSB-first stream bytes into 32-bit words; word_ready_o flags the acceptance completing a word.
module byte_word_packer
    import loader_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear_i,
    input  logic                     accept_i,
    input  logic [7:0]               byte_i,
    output logic [LOADER_WORD_W-1:0] word_o,
    output logic                     word_ready_o
);
    logic [LOADER_WORD_W-1:0] word_q, word_d;
    logic [1:0]               idx_q, idx_d;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (clear_i) begin
            word_d = '0;
            idx_d  = '0;
        end else if (accept_i) begin
            word_d = {word_q[LOADER_WORD_W-9:0], byte_i};
            idx_d  = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign word_o       = word_q;
    assign word_ready_o = accept_i && !clear_i && (idx_q == 2'(LOADER_WORD_BYTES - 1));

endmodule

// File: rtl/program_loader.sv
// Program loader: framed byte stream (count, MSB-first words) into the instruction/data memory.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 600,
    parameter int BASE_ADDR = 0
) (
    input logic             clock,
    input logic             reset,
    program_loader_if.master bus
);
    localparam int unsigned       MAX_WORDS = DEPTH - BASE_ADDR;
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam loader_state_t     S_LAST    = S_CHECK;
`else
    localparam loader_state_t     S_LAST    = S_DONE;
`endif

    loader_state_t             state_q, state_d;
    logic [LOADER_COUNT_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [15:0]               words_q, words_d;
    logic [7:0]                csum_q, csum_d;
    logic                      byte_ready_q, byte_ready_d;
    logic                      write_q, write_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      error_q, error_d;

    logic                      accept, start_take, word_ready;
    logic [LOADER_COUNT_W-1:0] len_full;
    logic [LOADER_WORD_W-1:0]  word;

    assign accept     = bus.byte_valid && byte_ready_q;
    assign start_take = bus.start && !is_busy(state_q);
    assign len_full   = {count_q[15:8], bus.byte_in};

    byte_word_packer u_packer (
        .clock        (clock),
        .reset        (reset),
        .clear_i      (start_take),
        .accept_i     (accept && state_q == S_DATA),
        .byte_i       (bus.byte_in),
        .word_o       (word),
        .word_ready_o (word_ready)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: each comb output gets a default first; a branch that skipped it would infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: if (start_take) state_d = S_LEN_HI;
            S_LEN_HI:                if (accept) state_d = S_LEN_LO;
            S_LEN_LO: if (accept) begin
                if (len_full == '0)                    state_d = S_LAST;
                else if (32'(len_full) > MAX_WORDS)    state_d = S_ERROR;
                else                                   state_d = S_DATA;
            end
            S_DATA:                  if (word_ready) state_d = S_WRITE;
            S_WRITE: state_d = (words_q + 16'd1 == count_q) ? S_LAST : S_DATA;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHECK: if (accept) state_d = ((csum_q ^ bus.byte_in) == 8'h00) ? S_DONE : S_ERROR;
`endif
            default:                 state_d = S_IDLE;
        endcase
    end

    // Datapath and registered outputs, all computed from the state being entered.
    always_comb begin
        count_d = count_q;
        addr_d  = addr_q;
        words_d = words_q;
        csum_d  = csum_q;
        if (start_take) begin
            count_d = '0;
            addr_d  = BASE;
            words_d = '0;
            csum_d  = '0;
        end else begin
            if (accept) csum_d = csum_q ^ bus.byte_in;
            if (accept && state_q == S_LEN_HI) count_d[15:8] = bus.byte_in;
            if (accept && state_q == S_LEN_LO) count_d[7:0]  = bus.byte_in;
            if (state_q == S_WRITE) begin
                addr_d  = addr_q + ADDR_W'(1);
                words_d = words_q + 16'd1;
            end
        end
        byte_ready_d = takes_bytes(state_d);
        write_d      = (state_d == S_WRITE);
        busy_d       = is_busy(state_d);
        done_d       = (state_d == S_DONE);
        error_d      = (state_d == S_ERROR);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q      <= '0;
            addr_q       <= BASE;
            words_q      <= '0;
            csum_q       <= '0;
            byte_ready_q <= 1'b0;
            write_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            count_q      <= count_d;
            addr_q       <= addr_d;
            words_q      <= words_d;
            csum_q       <= csum_d;
            byte_ready_q <= byte_ready_d;
            write_q      <= write_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign bus.byte_ready   = byte_ready_q;
    assign bus.dado         = word;
    assign bus.endereco     = addr_q;
    assign bus.write        = write_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.error        = error_q;
    assign bus.words_loaded = words_q;

endmodule
